pbutton_bounce_gen: RTL
=======================

# pbutton_bounce_gen

Synthetic push-button source: on request, drives an active-low KEY-style line through a configurable bounce window and then settles it at the requested level. It is the driving end of the button interface that `pbutton_debouncer` consumes. On the DE2-115 debouncer bench it is looped into a debouncer (internally or via GPIO), so debounce timing is checked repeatably without a human pressing keys.

## Interface
- `CHIP_LOG2`, default 10: bounce granularity; PB may change level once every 2^CHIP_LOG2 cycles (20.48 us at 50 MHz).
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `press_req`  in  1  single-cycle request to drive PB low (pressed).
- `release_req`  in  1  single-cycle request to drive PB high (released).
- `nb_bounce_cycle`  in  32  bounce window length N in cycles; sampled only when a request is accepted.
- `PB`  out  1  generated button line, active-low, registered.
- `pb_pressed`  out  1  settled logical state, 1 = pressed.
- `busy`  out  1  bounce window in progress.
- `done`  out  1  one-cycle pulse when PB has settled at its target level.
- `req_dropped`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values: PB=1, pb_pressed=0, busy=0, done=0, req_dropped=0; FSM in IDLE; bounce counter 0; LFSR reseeded.
- FSM states are IDLE and BOUNCE.
- IDLE with exactly one request asserted: latch target (press gives 0, release gives 1) and latch N.
  - Drive PB to the target on the next edge.
  - If N=0: pulse done and stay in IDLE.
  - Otherwise: clear the counter and enter BOUNCE.
- BOUNCE: the counter increments every cycle.
  - At each nonzero multiple of 2^CHIP_LOG2 below N, PB is updated to the target if the bounce bit is 1, else to the inverse of the target.
  - When the counter reaches N-1, PB is forced to the target, busy falls, done pulses, and the FSM returns to IDLE.
- pb_pressed updates in the same cycle done pulses.
- Both requests asserted in the same cycle in IDLE: neither is accepted and req_dropped pulses.
- Any request while in BOUNCE: ignored and req_dropped pulses; the current operation is unaffected.
- Request matching the current settled state (for example press when pb_pressed=1): accepted normally. PB may still bounce; the behaviour is not special-cased.
- Changing nb_bounce_cycle mid-window has no effect.
- RESET_N low mid-window: next edge restores all reset values and the operation is abandoned with no done pulse.

## Timing
- Request sampled at edge k; PB shows its first transition after edge k+1.
- busy is high after edges k+1 through k+N-1 for N≥2, and never high for N≤1.
- done pulses after edge k+max(N,1); PB is stable at the target from that same edge onward.
- Throughput: a new request is accepted in the cycle done is high, since the FSM is already in IDLE.
- Counter width is 32 bits; N up to 2^32-1 with no wrap inside a window.

## Configuration
- `PB_BOUNCE_GEN_LFSR_EN` defined:
  - The bounce bit is bit 0 of a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1.
  - The LFSR advances only at chip boundaries inside BOUNCE.
  - The sequence is reproducible after reset.
- Not defined: the bounce bit alternates 0,1,0,1,... starting at 0 for each window, giving a deterministic square-wave bounce.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package `pbutton_pkg`: FSM state enum, LFSR width, taps and seed constants, and the default CHIP_LOG2.
- One sub-module, `lfsr16`, with ports clk, rst_n, advance and q[15:0]. It is instantiated only under `PB_BOUNCE_GEN_LFSR_EN`.
- Top-level board wrappers connect PB to a `pbutton_debouncer` PB input or to a GPIO pin.

## Test plan
- Reset with RESET_N=0 for 2 cycles → PB=1, busy=0, done=0, pb_pressed=0.
- CHIP_LOG2=2, LFSR off, N=16, press_req at edge k → PB=0 after k+1. PB=1 after k+5, 0 after k+9, 1 after k+13, then forced 0 with done after k+16; pb_pressed=1.
- N=0 release_req → PB=1 and done both after k+1; busy never asserted.
- press_req during BOUNCE, and press_req+release_req together in IDLE → req_dropped pulses for 1 cycle each; the in-flight window completes with unchanged timing.
- RESET_N low at the midpoint of an N=1000 window → PB=1 next edge, no done; a subsequent press with N=8 completes normally.
- LFSR on, N=150000, loopback into `pbutton_debouncer` with nb_debounce_cycle=150000, 10 press/release pairs → exactly 10 pushed and 10 released pulses.

Source files
------------

// File: rtl/pbutton_pkg.sv
// Shared types and constants for the synthetic push-button generator.
// The LFSR constants are only consumed when PB_BOUNCE_GEN_LFSR_EN is defined.
package pbutton_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    localparam int unsigned CHIP_LOG2_DEFAULT = 10;

    localparam int unsigned         LFSR_W    = 16;
    localparam logic [LFSR_W-1:0]   LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci form: taps 16,14,13,11 feed back from bits 0,2,3,5.
    localparam logic [LFSR_W-1:0]   LFSR_TAPS = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/pbutton_bounce_gen_if.sv
// Request/status bundle between a button-generator driver (master) and
// pbutton_bounce_gen (slave).
interface pbutton_bounce_gen_if;

    logic        press_req;
    logic        release_req;
    logic [31:0] nb_bounce_cycle;
    logic        PB;
    logic        pb_pressed;
    logic        busy;
    logic        done;
    logic        req_dropped;

    modport master (
        output press_req, release_req, nb_bounce_cycle,
        input  PB, pb_pressed, busy, done, req_dropped
    );

    modport slave (
        input  press_req, release_req, nb_bounce_cycle,
        output PB, pb_pressed, busy, done, req_dropped
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random bounce source.
// Only built when PB_BOUNCE_GEN_LFSR_EN is defined.
`ifdef PB_BOUNCE_GEN_LFSR_EN
module lfsr16
    import pbutton_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule
`endif

// File: rtl/pbutton_bounce_gen.sv
// Synthetic active-low push-button source with a chip-granular bounce window.
// Define PB_BOUNCE_GEN_LFSR_EN for pseudo-random bounce; otherwise a square wave.
module pbutton_bounce_gen
    import pbutton_pkg::*;
#(
    parameter int unsigned CHIP_LOG2 = CHIP_LOG2_DEFAULT
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    pbutton_bounce_gen_if.slave  bus
);

    localparam logic [31:0] CHIP_MASK = 32'((64'd1 << CHIP_LOG2) - 64'd1);

    state_t      state, state_next;
    logic [31:0] cnt, cnt_inc, n_q;
    logic        target_q, start_q, pb_q, pressed_q, done_q, dropped_q;
    logic        one_req, any_req;
    logic        in_bounce, first, finish, chip_tick, bounce_bit;

    assign one_req   = bus.press_req ^ bus.release_req;
    assign any_req   = bus.press_req | bus.release_req;
    assign in_bounce = (state == ST_BOUNCE);
    assign cnt_inc   = cnt + 32'd1;

    // cnt holds the window position of the previous edge, so it is the
    // position being evaluated at this edge.
    assign first     = in_bounce && (cnt == '0);
    assign finish    = in_bounce && (cnt_inc == n_q);
    assign chip_tick = in_bounce && (cnt != '0) && ((cnt & CHIP_MASK) == '0) && !finish;

`ifdef PB_BOUNCE_GEN_LFSR_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .advance (chip_tick),
        .q       (lfsr_q)
    );

    assign bounce_bit  = lfsr_q[0];
    assign unused_lfsr = ^lfsr_q[15:1];
`else
    logic bounce_tgl;

    // Restarts at 0 for every window.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || !in_bounce) begin
            bounce_tgl <= 1'b0;
        end else if (chip_tick) begin
            bounce_tgl <= ~bounce_tgl;
        end
    end

    assign bounce_bit = bounce_tgl;
`endif

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE:   if (one_req && (bus.nb_bounce_cycle != '0)) state_next = ST_BOUNCE;
            ST_BOUNCE: if (finish) state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            n_q       <= '0;
            target_q  <= 1'b1;
            start_q   <= 1'b0;
            pb_q      <= 1'b1;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_next;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            start_q   <= 1'b0;
            if (state == ST_IDLE) begin
                // Zero-length window accepted on the previous edge completes now.
                if (start_q) begin
                    pb_q      <= target_q;
                    pressed_q <= ~target_q;
                    done_q    <= 1'b1;
                end
                if (one_req) begin
                    target_q <= bus.release_req;
                    n_q      <= bus.nb_bounce_cycle;
                    cnt      <= '0;
                    start_q  <= (bus.nb_bounce_cycle == '0);
                end else if (any_req) begin
                    dropped_q <= 1'b1;
                end
            end else begin
                cnt       <= cnt_inc;
                dropped_q <= any_req;
                if (finish || first) begin
                    pb_q <= target_q;
                    if (finish) begin
                        pressed_q <= ~target_q;
                        done_q    <= 1'b1;
                    end
                end else if (chip_tick) begin
                    pb_q <= bounce_bit ? target_q : ~target_q;
                end
            end
        end
    end

    assign bus.PB          = pb_q;
    assign bus.pb_pressed  = pressed_q;
    assign bus.busy        = in_bounce && (cnt != '0);
    assign bus.done        = done_q;
    assign bus.req_dropped = dropped_q;

endmodule
